// File: rtl/alu_result_writeback_if.sv
// Operand-read, ALU write-back and external-load signals around the register file.
// The master side is whoever drives the ALU result and loads; the slave side is the register file.
interface alu_result_writeback_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] alu_out;
    logic              alu_z;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              z_flag;
    logic              ld_drop;
    logic [7:0]        wb_count;

    modport master (
        output wb_valid, wb_addr, alu_out, alu_z,
        output ld_valid, ld_addr, ld_data,
        output rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, z_flag, ld_drop, wb_count
    );

    modport slave (
        input  wb_valid, wb_addr, alu_out, alu_z,
        input  ld_valid, ld_addr, ld_data,
        input  rd_addr1, rd_addr2,
        output rd_data1, rd_data2, z_flag, ld_drop, wb_count
    );
endinterface

// File: rtl/alu_result_writeback.sv
// Register file and write-back stage around the 8-bit ALU.
// Writes are captured into a one-entry pending register and committed to the
// array on the following edge; the read ports bypass from the pending entry so
// a result is visible one edge after it is presented.
module alu_result_writeback #(
    parameter int NREGS  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_result_writeback_if.slave  bus
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              z_q;
    logic              drop_q;
    logic [7:0]        count_q;

    // Capture the winning write source into the pending entry while the
    // previous pending entry commits to the array in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            z_q        <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            if (bus.wb_valid) begin
                pend_valid <= 1'b1;
                pend_addr  <= bus.wb_addr;
                pend_data  <= bus.alu_out;
                z_q        <= bus.alu_z;
            end else if (bus.ld_valid) begin
                pend_valid <= 1'b1;
                pend_addr  <= bus.ld_addr;
                pend_data  <= bus.ld_data;
            end else begin
                pend_valid <= 1'b0;
            end

            // A load colliding with an ALU result loses and is reported.
            drop_q <= bus.wb_valid & bus.ld_valid;

            if (pend_valid) begin
                regs[pend_addr] <= pend_data;
                count_q         <= count_q + 8'd1;
            end
        end
    end

    // Combinational read ports; the pending entry is newer than the array.
    always_comb begin
        bus.rd_data1 = regs[bus.rd_addr1];
        bus.rd_data2 = regs[bus.rd_addr2];
        if (pend_valid && (pend_addr == bus.rd_addr1)) begin
            bus.rd_data1 = pend_data;
        end
        if (pend_valid && (pend_addr == bus.rd_addr2)) begin
            bus.rd_data2 = pend_data;
        end
    end

    assign bus.z_flag   = z_q;
    assign bus.ld_drop  = drop_q;
    assign bus.wb_count = count_q;

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed, table-driven bench for alu_result_writeback.
module tb_alu_result_writeback;

    logic clk;
    logic reset;

    alu_result_writeback_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    alu_result_writeback #(.NREGS(8), .DATA_W(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wv;
        logic [2:0] wa;
        logic [7:0] ao;
        logic       az;
        logic       lv;
        logic [2:0] la;
        logic [7:0] ldd;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       ez;
        logic       edrop;
        logic [7:0] ecnt;
    } vec_t;

    localparam int NVEC = 13;
    vec_t tbl [NVEC];

    int vectors;
    int miscompares;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.wb_valid = 1'b0;
        bus.wb_addr  = '0;
        bus.alu_out  = '0;
        bus.alu_z    = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                              input logic ez, input logic edrop, input logic [7:0] ecnt);
        vectors++;
        check({tag, " rd_data1"}, bus.rd_data1, e1);
        check({tag, " rd_data2"}, bus.rd_data2, e2);
        check({tag, " z_flag"},   {7'd0, bus.z_flag}, {7'd0, ez});
        check({tag, " ld_drop"},  {7'd0, bus.ld_drop}, {7'd0, edrop});
        check({tag, " wb_count"}, bus.wb_count, ecnt);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        //             wv   wa    ao     az   lv   la    ld     r1    r2    e1     e2     ez   drp  cnt
        tbl[0]  = '{1'b0,3'd0,8'h00,1'b0,1'b1,3'd2,8'h3C,3'd2,3'd0,8'h3C,8'h00,1'b0,1'b0,8'd0};
        tbl[1]  = '{1'b0,3'd0,8'h00,1'b0,1'b0,3'd0,8'h00,3'd2,3'd2,8'h3C,8'h3C,1'b0,1'b0,8'd1};
        tbl[2]  = '{1'b1,3'd5,8'h00,1'b1,1'b0,3'd0,8'h00,3'd2,3'd5,8'h3C,8'h00,1'b1,1'b0,8'd1};
        tbl[3]  = '{1'b1,3'd5,8'h7F,1'b0,1'b0,3'd0,8'h00,3'd5,3'd5,8'h7F,8'h7F,1'b0,1'b0,8'd2};
        tbl[4]  = '{1'b0,3'd0,8'h00,1'b0,1'b0,3'd0,8'h00,3'd5,3'd2,8'h7F,8'h3C,1'b0,1'b0,8'd3};
        tbl[5]  = '{1'b1,3'd1,8'hAA,1'b0,1'b1,3'd3,8'h55,3'd1,3'd3,8'hAA,8'h00,1'b0,1'b1,8'd3};
        tbl[6]  = '{1'b0,3'd0,8'h00,1'b0,1'b0,3'd0,8'h00,3'd1,3'd3,8'hAA,8'h00,1'b0,1'b0,8'd4};
        tbl[7]  = '{1'b1,3'd6,8'h00,1'b1,1'b0,3'd0,8'h00,3'd6,3'd1,8'h00,8'hAA,1'b1,1'b0,8'd4};
        tbl[8]  = '{1'b0,3'd0,8'h00,1'b0,1'b1,3'd6,8'h99,3'd6,3'd6,8'h99,8'h99,1'b1,1'b0,8'd5};
        tbl[9]  = '{1'b0,3'd0,8'h00,1'b0,1'b1,3'd0,8'hE1,3'd6,3'd0,8'h99,8'hE1,1'b1,1'b0,8'd6};
        tbl[10] = '{1'b1,3'd7,8'hFF,1'b0,1'b0,3'd0,8'h00,3'd0,3'd7,8'hE1,8'hFF,1'b0,1'b0,8'd7};
        tbl[11] = '{1'b0,3'd0,8'h00,1'b0,1'b0,3'd0,8'h00,3'd7,3'd3,8'hFF,8'h00,1'b0,1'b0,8'd8};
        tbl[12] = '{1'b0,3'd0,8'h00,1'b0,1'b0,3'd0,8'h00,3'd0,3'd1,8'hE1,8'hAA,1'b0,1'b0,8'd8};

        // Reset and read every address on both ports.
        drive_idle();
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.rd_addr1 = 3'(i);
            bus.rd_addr2 = 3'(7 - i);
            #1;
            check_outs($sformatf("reset a%0d", i), 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
        end

        // Table of single-cycle vectors; expectations are after the edge.
        for (int v = 0; v < NVEC; v++) begin
            bus.wb_valid = tbl[v].wv;
            bus.wb_addr  = tbl[v].wa;
            bus.alu_out  = tbl[v].ao;
            bus.alu_z    = tbl[v].az;
            bus.ld_valid = tbl[v].lv;
            bus.ld_addr  = tbl[v].la;
            bus.ld_data  = tbl[v].ldd;
            bus.rd_addr1 = tbl[v].r1;
            bus.rd_addr2 = tbl[v].r2;
            step();
            check_outs($sformatf("vec%0d", v), tbl[v].e1, tbl[v].e2, tbl[v].ez, tbl[v].edrop, tbl[v].ecnt);
        end

        // Pending write in flight when reset asserts is discarded.
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 3'd4;
        bus.alu_out  = 8'h11;
        bus.alu_z    = 1'b1;
        bus.rd_addr1 = 3'd4;
        bus.rd_addr2 = 3'd1;
        step();
        check_outs("pre-reset", 8'h11, 8'hAA, 1'b1, 1'b0, 8'd8);
        drive_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_outs("in-reset", 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
        step();
        check_outs("post-reset", 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);

        // 256 consecutive loads: count trails by one edge, then wraps to 0.
        bus.rd_addr1 = 3'd7;
        bus.rd_addr2 = 3'd0;
        for (int k = 0; k < 256; k++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 3'(k % 8);
            bus.ld_data  = 8'(k);
            step();
            vectors++;
            check($sformatf("load%0d wb_count", k), bus.wb_count, 8'(k));
        end
        drive_idle();
        step();
        check_outs("wrap", 8'hFF, 8'hF8, 1'b0, 1'b0, 8'd0);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 3'd0;
        bus.ld_data  = 8'h5A;
        step();
        drive_idle();
        step();
        check_outs("load257", 8'hFF, 8'h5A, 1'b0, 1'b0, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Register-file and write-back stage that sits directly around the 8-bit ALU.
- Two combinational read ports drive the ALU in1/in2 operands.
- ALU out/Z are captured into a one-entry write-back pipeline register, then committed to the register array on the following edge.
- Holds the architectural zero flag, accepts external loads (immediate/memory), and counts retired writes.

Parameters:
- NREGS, 8, number of general registers
- DATA_W, 8, register / ALU data width
- ADDR_W, 3, register address width (log2 NREGS)

Ports:
- clk  input  1  single system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- wb_valid  input  1  ALU result valid this cycle
- wb_addr  input  ADDR_W  destination register for ALU result
- alu_out  input  DATA_W  ALU result
- alu_z  input  1  ALU zero indication
- ld_valid  input  1  external load valid
- ld_addr  input  ADDR_W  destination register for load
- ld_data  input  DATA_W  load data
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  read port 1 data (to ALU in1)
- rd_data2  output  DATA_W  read port 2 data (to ALU in2)
- z_flag  output  1  registered zero flag
- ld_drop  output  1  one-cycle pulse: a load lost arbitration
- wb_count  output  8  retired-write counter

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- Reset values (next rising edge with reset=1): all NREGS registers 0, pend_valid 0, pend_addr 0, pend_data 0, z_flag 0, ld_drop 0, wb_count 0.
- A pending write in flight when reset asserts is discarded. Reset has priority over all other inputs.
- Capture stage (each edge, reset=0):
  - wb_valid=1: pend_valid<=1, pend_addr<=wb_addr, pend_data<=alu_out, z_flag<=alu_z.
  - else ld_valid=1: pend_valid<=1, pend_addr<=ld_addr, pend_data<=ld_data; z_flag unchanged.
  - else pend_valid<=0.
  - wb_valid and ld_valid both 1: ALU result wins, load is discarded, ld_drop<=1 for exactly one cycle. Otherwise ld_drop<=0.
- Commit stage (same edge, uses pre-edge pending values): if pend_valid=1, regs[pend_addr]<=pend_data and wb_count<=wb_count+1, wrapping 255->0.
  - Capture and commit run concurrently, so one write per cycle is sustained with no stall.
- Write latency: input at edge N becomes visible on a read port after edge N (bypass from the pending register) and in the array after edge N+1.
- Read ports are combinational:
  - rd_dataX = pend_data when pend_valid=1 and pend_addr==rd_addrX; otherwise regs[rd_addrX].
  - Same-cycle wb/ld inputs are never forwarded to the read ports.
- Both ports reading the same address return identical data.
- Back-to-back writes to the same address commit in arrival order. The bypass always shows the newest pending value, never a stale array value.
- z_flag changes only on accepted ALU write-backs, never on loads.
- Every address in 0..NREGS-1 is writable; there is no hardwired zero register.

Test Plan:
- Reset, then read all addresses on both ports -> every rd_data=0, z_flag=0, wb_count=0, ld_drop=0.
- ld_valid, ld_addr=2, ld_data=8'h3C for 1 cycle -> next cycle rd_addr1=2 gives 8'h3C via bypass; one cycle later still 8'h3C from array; wb_count=1; z_flag unchanged.
- wb_valid, wb_addr=5, alu_out=8'h00, alu_z=1, then next cycle wb_valid, wb_addr=5, alu_out=8'h7F, alu_z=0 -> z_flag 1 then 0; rd_addr2=5 reads 8'h00 then 8'h7F; final array[5]=8'h7F; wb_count +2.
- Same cycle wb_valid (addr 1, 8'hAA) and ld_valid (addr 3, 8'h55) -> ld_drop=1 for one cycle; reg1=8'hAA; reg3 unchanged (0).
- Issue wb_valid addr 4 data 8'h11, assert reset on the following edge -> reg4 reads 0, wb_count=0, pend_valid cleared.
- 256 consecutive loads -> wb_count wraps to 0; 257th -> 1.
